// File: rtl/wb_ram_pkg.sv
// Shared parameter header: instruction-set constants used across the core,
// plus the Wishbone bus widths and the wb_ram controller state encoding.
package wb_ram_pkg;

    // Opcode / funct3 constants for the load-store path
    localparam logic [6:0] OPC_LOAD  = 7'b000_0011;
    localparam logic [6:0] OPC_STORE = 7'b010_0011;
    localparam logic [2:0] F3_BYTE   = 3'b000;
    localparam logic [2:0] F3_HALF   = 3'b001;
    localparam logic [2:0] F3_WORD   = 3'b010;

    // Wishbone width constants
    localparam int WB_ADR_W  = 32;
    localparam int WB_DAT_W  = 32;
    localparam int WB_SEL_W  = 4;
    localparam int WB_BYTE_W = 8;

    // Slave controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } wb_state_e;

endpackage

// File: rtl/wb_ram_array.sv
// Single-port word storage with synchronous read and byte-lane write.
// Read data is presented for exactly one cycle after a read access and is
// zero otherwise, so it can drive the bus data output directly.
module wb_ram_array
    import wb_ram_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = 10
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en_i,
    input  logic                we_i,
    input  logic [WB_SEL_W-1:0] sel_i,
    input  logic [AW-1:0]       addr_i,
    input  logic [WB_DAT_W-1:0] wdata_i,
    output logic [WB_DAT_W-1:0] rdata_o
);

    logic [WB_DAT_W-1:0] mem_r [DEPTH_WORDS];
    logic [WB_DAT_W-1:0] rdata_r;

    // Byte-lane write; contents deliberately survive reset
    always_ff @(posedge clk_i) begin
        if (en_i && we_i) begin
            for (int b = 0; b < WB_SEL_W; b++) begin
                if (sel_i[b]) begin
                    mem_r[addr_i][b*WB_BYTE_W +: WB_BYTE_W] <= wdata_i[b*WB_BYTE_W +: WB_BYTE_W];
                end
            end
        end
    end

    // Synchronous read register, zero whenever no read is being answered
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rdata_r <= {WB_DAT_W{1'b0}};
        end else if (en_i && !we_i) begin
            rdata_r <= mem_r[addr_i];
        end else begin
            rdata_r <= {WB_DAT_W{1'b0}};
        end
    end

    assign rdata_o = rdata_r;

endmodule

// File: rtl/wb_ram.sv
// Wishbone classic slave in front of wb_ram_array. One transaction at a
// time: IDLE accepts, optional WAIT burns WAIT_STATES cycles, RESP gives a
// one-cycle ack (in range) or err (out of range). Memory is accessed on the
// edge entering RESP, so write commit and read data line up with the ack.
module wb_ram
    import wb_ram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                cyc_i,
    input  logic                stb_i,
    input  logic                we_i,
    input  logic [WB_ADR_W-1:0] adr_i,
    input  logic [WB_SEL_W-1:0] sel_i,
    input  logic [WB_DAT_W-1:0] dat_i,
    output logic [WB_DAT_W-1:0] dat_o,
    output logic                ack_o,
    output logic                err_o,
    output logic                rty_o
);

    localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) << 2;
    localparam bit          NO_WAIT   = (WAIT_STATES == 0);
    localparam logic [3:0]  WAIT_INIT = NO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

    wb_state_e             state_r, state_nxt_s;
    logic [3:0]            count_r, count_nxt_s;
    logic                  we_r, hit_r;
    logic [WB_SEL_W-1:0]   sel_r;
    logic [WB_DAT_W-1:0]   dat_r;
    logic [AW-1:0]         idx_r;
    logic                  ack_r, err_r;

    logic [WB_ADR_W-1:0]   offset_s;
    logic                  in_range_s;
    logic [AW-1:0]         index_s;
    logic                  req_s, enter_resp_s, mem_en_s;
    logic                  acc_we_s, acc_hit_s;
    logic [WB_SEL_W-1:0]   acc_sel_s;
    logic [WB_DAT_W-1:0]   acc_dat_s;
    logic [AW-1:0]         acc_idx_s;

    // Address decode; the subtraction wraps, so the lower-bound test is separate
    always_comb begin
        offset_s   = adr_i - BASE_ADDR;
        in_range_s = (adr_i >= BASE_ADDR) && ({1'b0, offset_s} < SPAN);
        index_s    = offset_s[AW+1:2];
    end

    // Next-state logic and selection of the access issued on the RESP entry edge
    always_comb begin
        req_s        = cyc_i & stb_i;
        state_nxt_s  = state_r;
        count_nxt_s  = count_r;
        enter_resp_s = 1'b0;
        acc_we_s     = we_r;
        acc_hit_s    = hit_r;
        acc_sel_s    = sel_r;
        acc_dat_s    = dat_r;
        acc_idx_s    = idx_r;
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    acc_we_s  = we_i;
                    acc_hit_s = in_range_s;
                    acc_sel_s = sel_i;
                    acc_dat_s = dat_i;
                    acc_idx_s = index_s;
                    if (NO_WAIT) begin
                        state_nxt_s  = ST_RESP;
                        enter_resp_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_WAIT;
                        count_nxt_s = WAIT_INIT;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!cyc_i) begin
                    state_nxt_s = ST_IDLE;
                    count_nxt_s = 4'd0;
                end else if (count_r == 4'd0) begin
                    state_nxt_s  = ST_RESP;
                    enter_resp_s = 1'b1;
                end else begin
                    count_nxt_s = count_r - 4'd1;
                end
            end
            ST_RESP: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                count_nxt_s = 4'd0;
            end
        endcase
        // reset suppresses any access so an interrupted write is dropped
        mem_en_s = enter_resp_s & acc_hit_s & rst_ni;
    end

    // State, wait counter and response flags
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
            count_r <= 4'd0;
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            count_r <= count_nxt_s;
            ack_r   <= enter_resp_s & acc_hit_s;
            err_r   <= enter_resp_s & ~acc_hit_s;
        end
    end

    // Request latch, loaded when IDLE accepts a request
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            we_r  <= 1'b0;
            hit_r <= 1'b0;
            sel_r <= {WB_SEL_W{1'b0}};
            dat_r <= {WB_DAT_W{1'b0}};
            idx_r <= {AW{1'b0}};
        end else if ((state_r == ST_IDLE) && req_s) begin
            we_r  <= we_i;
            hit_r <= in_range_s;
            sel_r <= sel_i;
            dat_r <= dat_i;
            idx_r <= index_s;
        end else begin
            we_r  <= we_r;
            hit_r <= hit_r;
            sel_r <= sel_r;
            dat_r <= dat_r;
            idx_r <= idx_r;
        end
    end

    wb_ram_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .en_i    (mem_en_s),
        .we_i    (acc_we_s),
        .sel_i   (acc_sel_s),
        .addr_i  (acc_idx_s),
        .wdata_i (acc_dat_s),
        .rdata_o (dat_o)
    );

    assign ack_o = ack_r;
    assign err_o = err_r;
    assign rty_o = 1'b0;

endmodule

// File: tb/tb_wb_ram.sv
// Bench for wb_ram: two instances (no wait states, three wait states) driven
// with directed and random Wishbone transfers against a word-array model.
module tb_wb_ram;

    localparam logic [31:0] BASE0 = 32'h0000_1000;
    localparam logic [31:0] BASE1 = 32'h8000_0000;
    localparam int          DEPTH = 16;
    localparam int          WS0   = 0;
    localparam int          WS1   = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cyc [2];
    logic        stb [2];
    logic        we  [2];
    logic        ack [2];
    logic        err [2];
    logic        rty [2];
    logic [31:0] adr [2];
    logic [31:0] wdat[2];
    logic [31:0] rdat[2];
    logic [3:0]  sel [2];

    logic [31:0] ref_mem [2][DEPTH];
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 clk = ~clk;

    wb_ram #(.BASE_ADDR(BASE0), .DEPTH_WORDS(DEPTH), .WAIT_STATES(WS0)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .cyc_i(cyc[0]), .stb_i(stb[0]), .we_i(we[0]),
        .adr_i(adr[0]), .sel_i(sel[0]), .dat_i(wdat[0]), .dat_o(rdat[0]),
        .ack_o(ack[0]), .err_o(err[0]), .rty_o(rty[0])
    );

    wb_ram #(.BASE_ADDR(BASE1), .DEPTH_WORDS(DEPTH), .WAIT_STATES(WS1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .cyc_i(cyc[1]), .stb_i(stb[1]), .we_i(we[1]),
        .adr_i(adr[1]), .sel_i(sel[1]), .dat_i(wdat[1]), .dat_o(rdat[1]),
        .ack_o(ack[1]), .err_o(err[1]), .rty_o(rty[1])
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] base_of(input int d);
        return (d == 0) ? BASE0 : BASE1;
    endfunction

    function automatic int lat_of(input int d);
        return ((d == 0) ? WS0 : WS1) + 1;
    endfunction

    // Reference model: decide the response and apply writes to the word array
    task automatic predict(input int d, input logic w, input logic [31:0] a,
                           input logic [3:0] s, input logic [31:0] wd,
                           output logic ex_ack, output logic ex_err, output logic [31:0] ex_dat);
        longint unsigned lo, aa;
        int              idx;
        logic [31:0]     mask;
        lo  = longint'(base_of(d));
        aa  = longint'(a);
        ex_dat = 32'h0;
        if (aa >= lo && aa < lo + 4 * DEPTH) begin
            ex_ack = 1'b1;
            ex_err = 1'b0;
            idx    = int'((aa - lo) / 4);
            if (w) begin
                mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
                ref_mem[d][idx] = (ref_mem[d][idx] & ~mask) | (wd & mask);
            end else begin
                ex_dat = ref_mem[d][idx];
            end
        end else begin
            ex_ack = 1'b0;
            ex_err = 1'b1;
        end
    endtask

    // Called just after the accepting edge; ends in the response cycle
    task automatic expect_resp(input int d, input logic ex_ack, input logic ex_err,
                               input logic [31:0] ex_dat, input string tag);
        int lat;
        lat = lat_of(d);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k < lat) begin
                check_eq({tag, "/wait_resp"}, {30'd0, ack[d], err[d]}, 32'd0);
                check_eq({tag, "/wait_dat"}, rdat[d], 32'd0);
            end else begin
                check_eq({tag, "/resp"}, {30'd0, ack[d], err[d]}, {30'd0, ex_ack, ex_err});
                check_eq({tag, "/dat"}, rdat[d], ex_dat);
            end
        end
    endtask

    task automatic drive(input int d, input logic w, input logic [31:0] a,
                         input logic [3:0] s, input logic [31:0] wd);
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; sel[d] = s; wdat[d] = wd;
    endtask

    task automatic release_bus(input int d);
        cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
    endtask

    // One complete transfer, started at a falling edge
    task automatic wb_xfer(input int d, input logic w, input logic [31:0] a,
                           input logic [3:0] s, input logic [31:0] wd, input string tag);
        logic        ex_ack, ex_err;
        logic [31:0] ex_dat;
        predict(d, w, a, s, wd, ex_ack, ex_err, ex_dat);
        drive(d, w, a, s, wd);
        @(posedge clk);
        expect_resp(d, ex_ack, ex_err, ex_dat, tag);
        release_bus(d);
        @(negedge clk);
        check_eq({tag, "/after"}, {29'd0, rty[d], ack[d], err[d]}, 32'd0);
        check_eq({tag, "/after_dat"}, rdat[d], 32'd0);
    endtask

    // Write then read the same word with the strobe held high throughout
    task automatic b2b(input int d, input logic [31:0] a, input logic [31:0] wd);
        logic        ex_ack, ex_err;
        logic [31:0] ex_dat;
        predict(d, 1'b1, a, 4'hF, wd, ex_ack, ex_err, ex_dat);
        drive(d, 1'b1, a, 4'hF, wd);
        @(posedge clk);
        expect_resp(d, ex_ack, ex_err, ex_dat, "b2b_wr");
        we[d] = 1'b0;
        predict(d, 1'b0, a, 4'hF, wd, ex_ack, ex_err, ex_dat);
        @(negedge clk);
        check_eq("b2b_gap", {30'd0, ack[d], err[d]}, 32'd0);
        @(posedge clk);
        expect_resp(d, ex_ack, ex_err, ex_dat, "b2b_rd");
        release_bus(d);
        @(negedge clk);
        check_eq("b2b_after", {30'd0, ack[d], err[d]}, 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        int          d, r;
        for (int i = 0; i < 2; i++) begin
            release_bus(i);
            adr[i] = 32'h0; sel[i] = 4'h0; wdat[i] = 32'h0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_eq("reset_flags", {29'd0, rty[i], ack[i], err[i]}, 32'd0);
            check_eq("reset_dat", rdat[i], 32'd0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Fill both memories so every later read has a known expectation
        for (int i = 0; i < 2; i++) begin
            for (int w = 0; w < DEPTH; w++) begin
                wb_xfer(i, 1'b1, base_of(i) + 32'(4 * w), 4'hF, $urandom, "fill");
            end
        end

        // Full-word write / readback without wait states
        wb_xfer(0, 1'b1, BASE0 + 32'd8, 4'hF, 32'hDEADBEEF, "dead_wr");
        wb_xfer(0, 1'b0, BASE0 + 32'd8, 4'h0, 32'h0, "dead_rd");

        // Byte lanes
        wb_xfer(0, 1'b1, BASE0 + 32'd4, 4'hF, 32'h11223344, "lane_init");
        wb_xfer(0, 1'b1, BASE0 + 32'd4, 4'b0100, 32'h00AA0000, "lane_wr");
        wb_xfer(0, 1'b0, BASE0 + 32'd4, 4'hF, 32'h0, "lane_rd");
        check_eq("lane_model", ref_mem[0][1], 32'h11AA3344);
        wb_xfer(0, 1'b1, BASE0 + 32'd4, 4'b0000, 32'hFFFFFFFF, "sel0_wr");
        wb_xfer(0, 1'b0, BASE0 + 32'd4, 4'hF, 32'h0, "sel0_rd");

        // Wait-state latency on the slow instance
        wb_xfer(1, 1'b0, BASE1 + 32'd12, 4'hF, 32'h0, "ws3_rd");
        wb_xfer(1, 1'b1, BASE1 + 32'd12, 4'hF, 32'h5A5A_A5A5, "ws3_wr");

        // Out of range just past the top, and below the base
        wb_xfer(0, 1'b1, BASE0 + 32'(4 * DEPTH), 4'hF, 32'h12345678, "oor_wr");
        wb_xfer(0, 1'b0, BASE0, 4'hF, 32'h0, "oor_word0");
        wb_xfer(1, 1'b0, BASE1 - 32'd4, 4'hF, 32'h0, "oor_below");

        // Master abort during WAIT
        drive(1, 1'b1, BASE1 + 32'd8, 4'hF, 32'hCAFEF00D);
        @(posedge clk);
        @(negedge clk);
        release_bus(1);
        repeat (6) begin
            @(negedge clk);
            check_eq("abort_resp", {30'd0, ack[1], err[1]}, 32'd0);
        end
        wb_xfer(1, 1'b0, BASE1 + 32'd8, 4'hF, 32'h0, "abort_rd");

        // Reset on the cycle before the response would start
        drive(1, 1'b1, BASE1 + 32'd16, 4'hF, 32'h0BAD0BAD);
        @(posedge clk);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("rst_wait_resp", {30'd0, ack[1], err[1]}, 32'd0);
        check_eq("rst_wait_dat", rdat[1], 32'd0);
        release_bus(1);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_idle_resp", {30'd0, ack[1], err[1]}, 32'd0);
        wb_xfer(1, 1'b0, BASE1 + 32'd16, 4'hF, 32'h0, "rst_rd");
        wb_xfer(0, 1'b0, BASE0 + 32'd8, 4'hF, 32'h0, "rst_keep");

        // Back-to-back with the strobe held high
        b2b(0, BASE0 + 32'd20, 32'h0123_4567);
        b2b(1, BASE1 + 32'd24, 32'h89AB_CDEF);

        // Random traffic
        for (int n = 0; n < 200; n++) begin
            d = int'($urandom_range(0, 1));
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                a = base_of(d) + 32'(4 * DEPTH) + 32'($urandom_range(0, 63));
            end else if (r == 1) begin
                a = base_of(d) - 32'd1 - 32'($urandom_range(0, 63));
            end else begin
                a = base_of(d) + 32'($urandom_range(0, 4 * DEPTH - 1));
            end
            wb_xfer(d, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
